// File: rtl/hs_fifo_sfifo.sv
// Single-clock packet FIFO: beats become readable only once their packet commits on wlast,
// and a wdrop beat rewinds the write pointer to discard the packet in progress.
module hs_fifo_sfifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned AF_THRESH  = FIFO_DEPTH - 2,
    parameter int unsigned AE_THRESH  = 1,
    localparam int unsigned LW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wlast,
    input  logic                  wdrop,
    output logic                  walmost_full,
    output logic [LW-1:0]         wlevel,
    input  logic                  rready,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rlast,
    output logic                  ralmost_empty,
    output logic [LW-1:0]         rlevel
);

    localparam int unsigned AW = LW - 1;

    logic [DATA_WIDTH:0] mem [FIFO_DEPTH];

    logic [LW-1:0] wr_ptr, cm_ptr, rd_ptr;
    logic [LW-1:0] wr_ptr_nxt, cm_ptr_nxt, rd_ptr_nxt;
    logic [LW-1:0] wlevel_nxt, rlevel_nxt;
    logic          wr_fire, rd_fire;
    logic [DATA_WIDTH:0] rd_entry;

    // Next pointer state; a drop rewinds to the last commit boundary.
    always_comb begin
        wr_fire    = wvalid && wready;
        rd_fire    = rvalid && rready;
        wr_ptr_nxt = wr_ptr;
        cm_ptr_nxt = cm_ptr;
        rd_ptr_nxt = rd_ptr;
        if (rd_fire) begin
            rd_ptr_nxt = rd_ptr + LW'(1);
        end
        if (wr_fire) begin
            if (wdrop) begin
                wr_ptr_nxt = cm_ptr;
            end else begin
                wr_ptr_nxt = wr_ptr + LW'(1);
                if (wlast) begin
                    cm_ptr_nxt = wr_ptr + LW'(1);
                end
            end
        end
        wlevel_nxt = wr_ptr_nxt - rd_ptr_nxt;
        rlevel_nxt = cm_ptr_nxt - rd_ptr_nxt;
    end

    // Pointers plus status outputs registered from their next-state values.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr        <= '0;
            cm_ptr        <= '0;
            rd_ptr        <= '0;
            wlevel        <= '0;
            rlevel        <= '0;
            wready        <= 1'b1;
            rvalid        <= 1'b0;
            walmost_full  <= 1'(AF_THRESH == 0);
            ralmost_empty <= 1'b1;
        end else begin
            wr_ptr        <= wr_ptr_nxt;
            cm_ptr        <= cm_ptr_nxt;
            rd_ptr        <= rd_ptr_nxt;
            wlevel        <= wlevel_nxt;
            rlevel        <= rlevel_nxt;
            wready        <= (wlevel_nxt != LW'(FIFO_DEPTH));
            rvalid        <= (cm_ptr_nxt != rd_ptr_nxt);
            walmost_full  <= (wlevel_nxt >= LW'(AF_THRESH));
            ralmost_empty <= (rlevel_nxt <= LW'(AE_THRESH));
        end
    end

    // Storage is not reset; unread entries are never overwritten.
    always_ff @(posedge clk) begin
        if (wr_fire && !wdrop) begin
            mem[wr_ptr[AW-1:0]] <= {wlast, wdata};
        end
    end

    assign rd_entry = mem[rd_ptr[AW-1:0]];
    assign rdata    = rd_entry[DATA_WIDTH-1:0];
    assign rlast    = rd_entry[DATA_WIDTH];

endmodule

// File: tb/tb_hs_fifo_sfifo.sv
// Bench for hs_fifo_sfifo: directed scenarios plus random traffic, checked every cycle
// against a queue-based packet model (committed queue + pending packet).
module tb_hs_fifo_sfifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          aresetn;
    logic          wvalid, wready, wlast, wdrop, walmost_full;
    logic [DW-1:0] wdata, rdata;
    logic [LW-1:0] wlevel, rlevel;
    logic          rready, rvalid, rlast, ralmost_empty;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW:0] cq[$];
    logic [DW:0] pq[$];

    always #5 clk = ~clk;

    hs_fifo_sfifo #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_THRESH(6), .AE_THRESH(1)
    ) dut (
        .clk(clk), .aresetn(aresetn),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast), .wdrop(wdrop),
        .walmost_full(walmost_full), .wlevel(wlevel),
        .rready(rready), .rvalid(rvalid), .rdata(rdata), .rlast(rlast),
        .ralmost_empty(ralmost_empty), .rlevel(rlevel)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, compare outputs to the model, advance model at posedge.
    task automatic step(input logic wv, input logic [DW-1:0] wd, input logic wl,
                        input logic wdr, input logic rr);
        int  lvl;
        bit  wfire, rfire;
        @(negedge clk);
        wvalid = wv; wdata = wd; wlast = wl; wdrop = wdr; rready = rr;
        lvl = cq.size() + pq.size();
        check("wready", wready, lvl != DEPTH);
        check("rvalid", rvalid, cq.size() > 0);
        check("wlevel", wlevel, lvl);
        check("rlevel", rlevel, cq.size());
        check("walmost_full", walmost_full, lvl >= 6);
        check("ralmost_empty", ralmost_empty, cq.size() <= 1);
        if (cq.size() > 0) begin
            check("rdata", rdata, cq[0][DW-1:0]);
            check("rlast", rlast, cq[0][DW]);
        end
        wfire = wv && (lvl != DEPTH);
        rfire = rr && (cq.size() > 0);
        @(posedge clk);
        if (rfire) void'(cq.pop_front());
        if (wfire) begin
            if (wdr) begin
                pq.delete();
            end else begin
                pq.push_back({wl, wd});
                if (wl) begin
                    while (pq.size() > 0) cq.push_back(pq.pop_front());
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wready"}, wready, 1);
        check({tag, "_rvalid"}, rvalid, 0);
        check({tag, "_wlevel"}, wlevel, 0);
        check({tag, "_rlevel"}, rlevel, 0);
        check({tag, "_af"}, walmost_full, 0);
        check({tag, "_ae"}, ralmost_empty, 1);
    endtask

    task automatic single_packet(input string tag);
        step(1, 8'h11, 0, 0, 1); #1 check({tag, "_wl1"}, wlevel, 1); check({tag, "_rv1"}, rvalid, 0);
        step(1, 8'h22, 0, 0, 1); #1 check({tag, "_wl2"}, wlevel, 2); check({tag, "_rl2"}, rlevel, 0);
        step(1, 8'h33, 1, 0, 1); #1 check({tag, "_rl3"}, rlevel, 3); check({tag, "_rv3"}, rvalid, 1);
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        #1 check({tag, "_empty"}, rvalid, 0);
    endtask

    initial begin
        logic          hold;
        logic          rwv, rwl, rwdr;
        logic [DW-1:0] rwd;

        aresetn = 1'b0;
        wvalid = 0; wdata = '0; wlast = 0; wdrop = 0; rready = 0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) aresetn = 1'b1;

        single_packet("sp");

        // Drop discards the uncommitted A-packet; only B0 survives.
        step(1, 8'hA0, 0, 0, 1);
        step(1, 8'hA1, 0, 0, 1);
        step(1, 8'hA2, 1, 1, 1); #1 check("drop_wlevel", wlevel, 0); check("drop_rvalid", rvalid, 0);
        step(1, 8'hB0, 1, 0, 1); #1 check("drop_b0_rdata", rdata, 8'hB0); check("drop_b0_rlast", rlast, 1);
        step(0, 8'h00, 0, 0, 1); #1 check("drop_empty", rvalid, 0);

        // Fill with single-beat packets, then try an extra beat.
        for (int i = 0; i < 8; i++) step(1, 8'(i), 1, 0, 0);
        #1 check("full_af", walmost_full, 1); check("full_wready", wready, 0); check("full_wlevel", wlevel, 8);
        step(1, 8'h08, 1, 0, 0); #1 check("full_no_accept", wlevel, 8);
        step(0, 8'h00, 0, 0, 1); #1 check("full_wready_back", wready, 1); check("full_wlevel7", wlevel, 7);

        // Backpressure hold, then concurrent read and write.
        for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 0, 0);
        step(1, 8'h55, 1, 0, 1); #1 check("concurrent_wlevel", wlevel, 7);
        for (int i = 0; i < 9; i++) step(0, 8'h00, 0, 0, 1);
        #1 check("drain_empty", rvalid, 0);

        // Async reset mid-packet with three committed entries.
        step(1, 8'hC0, 1, 0, 0);
        step(1, 8'hC1, 1, 0, 0);
        step(1, 8'hC2, 1, 0, 0);
        step(1, 8'hD0, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        #2 aresetn = 1'b0;
        #1 check_reset_outputs("async");
        cq.delete(); pq.delete();
        @(posedge clk);
        @(negedge clk) aresetn = 1'b1;
        single_packet("post");

        // Random traffic; packets capped at 4 beats, stalled beats held stable.
        hold = 0; rwv = 0; rwd = '0; rwl = 0; rwdr = 0;
        for (int c = 0; c < 3000; c++) begin
            logic rr;
            if (!hold) begin
                rwv  = ($urandom_range(0, 3) != 0);
                rwd  = 8'($urandom);
                rwdr = ($urandom_range(0, 15) == 0);
                rwl  = ($urandom_range(0, 2) == 0) || (pq.size() >= 3);
            end
            rr   = ($urandom_range(0, 2) != 0);
            hold = rwv && ((cq.size() + pq.size()) == DEPTH);
            step(rwv, rwd, rwl, rwdr, rr);
        end
        for (int i = 0; i < 12; i++) step(0, 8'h00, 0, 0, 1);
        #1 check("final_empty", rvalid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
